// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter, 8N1/8N2 framing with line BREAK.
// Fractional (Bresenham) baud generator keeps the long-term bit rate exact.
// Optional even parity bit: define UART_TX_PARITY_EN (8E1/8E2 frames).
// Ports:
//   CLK_I       system clock, rising edge
//   RST_NI      asynchronous active-low reset
//   TX_START_I  byte valid; accepted when TX_READY_O && !BRK_I
//   DATA_I      byte to send, sampled on the accept cycle
//   TX_READY_O  block can accept a byte or a break
//   BRK_I       break request, level-sensitive, wins over TX_START_I
//   TX_DONE_O   one-cycle pulse at the end of a frame or a break
//   TX_O        registered serial line, idles high
module uart_tx_framer #(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 1,
    parameter int BRK_BITS  = 11
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       TX_START_I,
    input  logic [7:0] DATA_I,
    output logic       TX_READY_O,
    input  logic       BRK_I,
    output logic       TX_DONE_O,
    output logic       TX_O
);

    localparam int AW = $clog2(CLK_RATE + BAUD_RATE);
`ifdef UART_TX_PARITY_EN
    localparam int BRK_MIN = (BRK_BITS > 12) ? BRK_BITS : 12;
`else
    localparam int BRK_MIN = BRK_BITS;
`endif
    localparam int BW = $clog2(BRK_MIN + 1);

    localparam logic [AW-1:0] BAUD_W   = AW'(BAUD_RATE);
    localparam logic [AW-1:0] CLK_W    = AW'(CLK_RATE);
    localparam logic [BW-1:0] BRK_LAST = BW'(BRK_MIN - 1);
    localparam logic [BW-1:0] BRK_SAT  = BW'(BRK_MIN);
    localparam logic [BW-1:0] BRK_ONE  = BW'(1);
    localparam logic [1:0]    STOP_N   = 2'(STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [AW-1:0]   acc_sum;
    logic            tick;
    logic [7:0]      shreg_q;
    logic [2:0]      idx_q;
    logic [1:0]      stop_q;
    logic [BW-1:0]   brk_cnt_q;
    logic            tx_q;
    logic            rdy_q;
    logic            done_q;
`ifdef UART_TX_PARITY_EN
    logic            par_q;
`endif

    // acc + BAUD never exceeds CLK + BAUD - 1, so AW bits hold the sum.
    always_comb begin
        acc_sum = acc_q + BAUD_W;
        tick    = (acc_sum >= CLK_W);
        acc_d   = tick ? (acc_sum - CLK_W) : acc_sum;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            shreg_q   <= '0;
            idx_q     <= '0;
            stop_q    <= '0;
            brk_cnt_q <= '0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                acc_q <= acc_d;
            end
            unique case (state_q)
                S_IDLE: begin
                    // Break has priority over a byte offered in the same cycle.
                    if (BRK_I) begin
                        state_q   <= S_BREAK;
                        tx_q      <= 1'b0;
                        rdy_q     <= 1'b0;
                        acc_q     <= '0;
                        brk_cnt_q <= '0;
                    end else if (TX_START_I && rdy_q) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        rdy_q   <= 1'b0;
                        acc_q   <= '0;
                        shreg_q <= DATA_I;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^DATA_I;
`endif
                    end
                end
                S_START: begin
                    if (tick) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tx_q    <= shreg_q[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg_q <= shreg_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            stop_q  <= STOP_N;
`endif
                        end else begin
                            tx_q <= shreg_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        stop_q  <= STOP_N;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (stop_q == 2'd1) begin
                            state_q <= S_IDLE;
                            rdy_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            stop_q <= stop_q - 2'd1;
                        end
                    end
                end
                S_BREAK: begin
                    // brk_cnt_q holds completed low periods, saturating at the minimum.
                    if (tick) begin
                        if (brk_cnt_q != BRK_SAT) begin
                            brk_cnt_q <= brk_cnt_q + BRK_ONE;
                        end
                        if (!BRK_I && (brk_cnt_q >= BRK_LAST)) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            stop_q  <= 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign TX_O       = tx_q;
    assign TX_READY_O = rdy_q;
    assign TX_DONE_O  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: three framer instances (10 clk/bit, 3.33 clk/bit,
// 10 clk/bit with two stop bits) checked against a bit-period model.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
    localparam int BRKL = 12;
`else
    localparam int PB = 0;
    localparam int BRKL = 11;
`endif

    logic       clk;
    logic       rst_n;
    logic       start [3];
    logic [7:0] data  [3];
    logic       brk   [3];
    logic       tx    [3];
    logic       rdy   [3];
    logic       done  [3];

    logic       exp_tx   [3];
    logic       exp_rdy  [3];
    logic       exp_done [3];

    int cyc;
    int ntests;
    int nfail;
    int ndone [3];

    uart_tx_framer #(
        .CLK_RATE(1000000), .BAUD_RATE(100000),
        .STOP_BITS(1), .BRK_BITS(11)
    ) u_a (
        .CLK_I(clk), .RST_NI(rst_n),
        .TX_START_I(start[0]), .DATA_I(data[0]),
        .TX_READY_O(rdy[0]), .BRK_I(brk[0]),
        .TX_DONE_O(done[0]), .TX_O(tx[0])
    );

    uart_tx_framer #(
        .CLK_RATE(1000000), .BAUD_RATE(300000),
        .STOP_BITS(1), .BRK_BITS(11)
    ) u_b (
        .CLK_I(clk), .RST_NI(rst_n),
        .TX_START_I(start[1]), .DATA_I(data[1]),
        .TX_READY_O(rdy[1]), .BRK_I(brk[1]),
        .TX_DONE_O(done[1]), .TX_O(tx[1])
    );

    uart_tx_framer #(
        .CLK_RATE(1000000), .BAUD_RATE(100000),
        .STOP_BITS(2), .BRK_BITS(11)
    ) u_c (
        .CLK_I(clk), .RST_NI(rst_n),
        .TX_START_I(start[2]), .DATA_I(data[2]),
        .TX_READY_O(rdy[2]), .BRK_I(brk[2]),
        .TX_DONE_O(done[2]), .TX_O(tx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    // ---------------- model ----------------
    function automatic longint crate(int i);
        return 64'd1000000;
    endfunction
    function automatic longint brate(int i);
        return (i == 1) ? 64'd300000 : 64'd100000;
    endfunction
    function automatic int sbits(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // A frame is a list of line levels, one per bit period; the n-th
    // period ends on the first cycle t (counted from 1 after the accept
    // edge) with t*BAUD >= n*CLK.
    bit     m_busy  [3];
    bit     m_brk   [3];
    bit     m_bstop [3];
    longint m_t     [3];
    longint m_m     [3];
    int     m_nb    [3];
    longint m_send  [3];
    bit     m_bits  [3][12];

    task automatic m_finish(int i);
        m_busy[i]   = 1'b0;
        exp_tx[i]   = 1'b1;
        exp_rdy[i]  = 1'b1;
        exp_done[i] = 1'b1;
    endtask

    task automatic m_step(int i);
        exp_done[i] = 1'b0;
        if (!m_busy[i]) begin
            if (brk[i]) begin
                m_busy[i]  = 1'b1;
                m_brk[i]   = 1'b1;
                m_bstop[i] = 1'b0;
                m_t[i]     = 0;
                m_m[i]     = 0;
                exp_tx[i]  = 1'b0;
                exp_rdy[i] = 1'b0;
            end else if (start[i]) begin
                m_busy[i]    = 1'b1;
                m_brk[i]     = 1'b0;
                m_t[i]       = 0;
                m_m[i]       = 0;
                m_bits[i][0] = 1'b0;
                for (int k = 0; k < 8; k++) m_bits[i][k+1] = data[i][k];
                if (PB == 1) m_bits[i][9] = ^data[i];
                m_nb[i] = 9 + PB + sbits(i);
                for (int k = 9 + PB; k < 12; k++) m_bits[i][k] = 1'b1;
                exp_tx[i]  = 1'b0;
                exp_rdy[i] = 1'b0;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] * brate(i) >= (m_m[i] + 1) * crate(i)) begin
                m_m[i]++;
                if (m_brk[i]) begin
                    if (!m_bstop[i]) begin
                        if (!brk[i] && m_m[i] >= BRKL) begin
                            m_bstop[i] = 1'b1;
                            m_send[i]  = m_m[i] + 1;
                            exp_tx[i]  = 1'b1;
                        end
                    end else if (m_m[i] == m_send[i]) begin
                        m_finish(i);
                    end
                end else if (m_m[i] < m_nb[i]) begin
                    exp_tx[i] = m_bits[i][m_m[i]];
                end else begin
                    m_finish(i);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_busy[i]   = 1'b0;
                    exp_tx[i]   = 1'b1;
                    exp_rdy[i]  = 1'b1;
                    exp_done[i] = 1'b0;
                end else begin
                    m_step(i);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_tx%0d", i), 32'(tx[i]), 32'(exp_tx[i]));
                chk($sformatf("model_rdy%0d", i), 32'(rdy[i]), 32'(exp_rdy[i]));
                chk($sformatf("model_done%0d", i), 32'(done[i]), 32'(exp_done[i]));
                if (done[i] === 1'b1) ndone[i]++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_rel(int a, int r);
        while (cyc - a + 1 < r) @(negedge clk);
    endtask

    task automatic send(int i, logic [7:0] d, output int a);
        int n;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_seen", 32'(n < 3000), 32'd1);
        start[i] = 1'b1;
        data[i]  = d;
        @(negedge clk);
        start[i] = 1'b0;
        a = cyc;
    endtask

    task automatic wait_done(int i, output int dc);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done[i]), 32'd1);
        dc = cyc;
    endtask

    // Receiver for 10-clock bit periods: samples each bit mid-period.
    task automatic rx(int i, logic [7:0] e, string nm);
        int n;
        int s;
        logic [7:0] b;
        n = 0;
        b = '0;
        while (tx[i] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        s = cyc;
        for (int k = 1; k <= 8; k++) begin
            while (cyc < s + 10 * k + 4) @(negedge clk);
            b[k-1] = tx[i];
        end
        while (cyc < s + 10 * (9 + PB) + 4) @(negedge clk);
        chk({nm, "_stop"}, 32'(tx[i]), 32'd1);
        chk(nm, 32'(b), 32'(e));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a;
        int dc;
        int d1;
        int b;
        int lo;
        int nd;
        int a5 [11];

        a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        if (PB == 1) a5[9] = 0;
        cyc = 0;
        ntests = 0;
        nfail = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            data[i]  = '0;
            brk[i]   = 1'b0;
            ndone[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx[0]), 32'd1);
        chk("reset_rdy", 32'(rdy[0]), 32'd1);
        chk("reset_done", 32'(done[0]), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Integer divide: 0xA5 at 10 clk/bit.
        send(0, 8'hA5, a);
        chk("a5_start_latency", 32'(tx[0]), 32'd0);
        chk("a5_busy", 32'(rdy[0]), 32'd0);
        for (int n = 0; n < 10 + PB; n++) begin
            wait_rel(a, 10 * n + 5);
            chk($sformatf("a5_bit%0d", n), 32'(tx[0]), 32'(a5[n]));
        end
        wait_done(0, dc);
        chk("a5_done_cycle", 32'(dc - a + 1), 32'(10 * (10 + PB) + 1));
        chk("a5_done_ready", 32'(rdy[0]), 32'd1);
        repeat (5) @(negedge clk);

        // Fractional divide: 0x00 at 3.33 clk/bit.
        send(1, 8'h00, a);
        lo = 0;
        while (tx[1] === 1'b0 && lo < 500) begin
            lo++;
            @(negedge clk);
        end
        chk("frac_low_len", 32'(lo), 32'((PB == 1) ? 34 : 30));
        wait_done(1, dc);
        chk("frac_done_cycle", 32'(dc - a + 1), 32'((PB == 1) ? 38 : 35));
        repeat (5) @(negedge clk);

        // Back-to-back with TX_START_I held: 0x55 then 0x0F.
        fork
            begin
                rx(0, 8'h55, "b2b_rx55");
                rx(0, 8'h0F, "b2b_rx0f");
            end
            begin
                start[0] = 1'b1;
                data[0]  = 8'h55;
                @(negedge clk);
                data[0] = 8'h0F;
                wait_done(0, d1);
                @(negedge clk);
                start[0] = 1'b0;
                chk("b2b_next_start", 32'(tx[0]), 32'd0);
                chk("b2b_gap", 32'(cyc - d1), 32'd1);
                wait_done(0, dc);
                chk("b2b_second_len", 32'(dc - d1), 32'(10 * (10 + PB) + 1));
            end
        join
        repeat (5) @(negedge clk);

        // Busy ignore, two stop bits.
        send(2, 8'h81, a);
        wait_rel(a, 40);
        start[2] = 1'b1;
        data[2]  = 8'hFF;
        @(negedge clk);
        start[2] = 1'b0;
        wait_rel(a, 10 * (9 + PB) + 5);
        chk("sb2_stop_first", 32'(tx[2]), 32'd1);
        wait_rel(a, 10 * (10 + PB) + 5);
        chk("sb2_stop_second", 32'(tx[2]), 32'd1);
        wait_done(2, dc);
        chk("sb2_done_cycle", 32'(dc - a + 1), 32'(10 * (11 + PB) + 1));
        @(negedge clk);
        nd = ndone[2];
        repeat (200) @(negedge clk);
        chk("sb2_no_extra_done", 32'(ndone[2] - nd), 32'd0);
        chk("sb2_idle_tx", 32'(tx[2]), 32'd1);

        // Break for 3 bit periods with a start request also high.
        brk[0]   = 1'b1;
        start[0] = 1'b1;
        data[0]  = 8'h12;
        @(negedge clk);
        b = cyc;
        lo = 0;
        while (tx[0] === 1'b0 && lo < 1000) begin
            lo++;
            if (lo == 30) begin
                brk[0]   = 1'b0;
                start[0] = 1'b0;
            end
            @(negedge clk);
        end
        chk("brk_low_len", 32'(lo), 32'(BRKL * 10));
        wait_done(0, dc);
        chk("brk_done_cycle", 32'(dc - b + 1), 32'(BRKL * 10 + 11));
        repeat (5) @(negedge clk);

        // Long break: low time rounds up to the next tick.
        brk[0] = 1'b1;
        @(negedge clk);
        b = cyc;
        lo = 0;
        while (tx[0] === 1'b0 && lo < 1000) begin
            lo++;
            if (lo == 145) brk[0] = 1'b0;
            @(negedge clk);
        end
        chk("brk_long_low_len", 32'(lo), 32'd150);
        wait_done(0, dc);
        chk("brk_long_done", 32'(dc - b + 1), 32'd161);
        repeat (5) @(negedge clk);

        // Reset mid-frame, then a clean resend.
        send(0, 8'h3C, a);
        wait_rel(a, 45);
        nd = ndone[0];
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx[0]), 32'd1);
        chk("rst_async_rdy", 32'(rdy[0]), 32'd1);
        chk("rst_async_done", 32'(done[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 32'(ndone[0] - nd), 32'd0);
        fork
            rx(0, 8'h3C, "rst_rx3c");
            begin
                send(0, 8'h3C, a);
`ifdef UART_TX_PARITY_EN
                wait_rel(a, 95);
                chk("par_3c", 32'(tx[0]), 32'd0);
`endif
                wait_done(0, dc);
                chk("rst_resend_done", 32'(dc - a + 1), 32'(10 * (10 + PB) + 1));
            end
        join
        fork
            rx(0, 8'h07, "rx07");
            begin
                send(0, 8'h07, a);
`ifdef UART_TX_PARITY_EN
                wait_rel(a, 95);
                chk("par_07", 32'(tx[0]), 32'd1);
`endif
                wait_done(0, dc);
            end
        join
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
